// File: rtl/stepdir_pkg.sv
// Shared defaults and constant helpers for the step/direction input decoder.
package stepdir_pkg;

   localparam int unsigned POS_W_DEF      = 32;
   localparam int unsigned PERIOD_W_DEF   = 24;
   localparam int unsigned FILTER_LEN_DEF = 4;
   localparam int unsigned DIR_SETUP_DEF  = 8;

   // All-ones value of a w-bit field, used as a saturation ceiling.
   function automatic logic [63:0] all_ones(input int unsigned w);
      if (w >= 64)
         return '1;
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/stepdir_if.sv
// Control/status bundle between the step/direction decoder and the register map.
interface stepdir_if
   import stepdir_pkg::*;
#(
   parameter int unsigned POS_W    = POS_W_DEF,
   parameter int unsigned PERIOD_W = PERIOD_W_DEF
);

   logic                STP;
   logic                DIR;
   logic                enable;
   logic                load;
   logic [POS_W-1:0]    load_value;
   logic                err_clr;
   logic [POS_W-1:0]    position;
   logic                step_pulse;
   logic                step_dir;
   logic [PERIOD_W-1:0] period;
   logic                period_valid;
   logic                setup_err;

   modport master (
      output STP, DIR, enable, load, load_value, err_clr,
      input  position, step_pulse, step_dir, period, period_valid, setup_err
   );

   modport slave (
      input  STP, DIR, enable, load, load_value, err_clr,
      output position, step_pulse, step_dir, period, period_valid, setup_err
   );

endinterface

// File: rtl/stepdir_input_filter.sv
// 2-FF synchroniser followed by a hold filter: a new level must persist
// FILTER_LEN synchronised cycles before the filtered output follows it.
module stepdir_input_filter #(
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic pin,
   output logic filt
);

   localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         filt  <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         if (sync2 == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            filt <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/stepdir_decoder.sv
// Step/direction receiver: filtered STP/DIR drive a position accumulator,
// a step-period counter and a direction-setup checker.
module stepdir_decoder
   import stepdir_pkg::*;
#(
   parameter int unsigned POS_W      = POS_W_DEF,
   parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
   parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
   parameter int unsigned DIR_SETUP  = DIR_SETUP_DEF
) (
   input  logic      sysclk,
   input  logic      rst_n,
   stepdir_if.slave  bus
);

   localparam logic [PERIOD_W-1:0] PERIOD_MAX = PERIOD_W'(all_ones(PERIOD_W));
   localparam int unsigned         AGE_W      = $clog2(DIR_SETUP + 1);
   localparam logic [AGE_W-1:0]    AGE_MAX    = AGE_W'(DIR_SETUP);

   logic                stp_filt;
   logic                dir_filt;
   logic                stp_prev;
   logic                dir_prev;
   logic                step_evt;
   logic                count_evt;
   logic                dir_chg;
   logic [AGE_W-1:0]    age;
   logic [AGE_W-1:0]    age_eff;
   logic [PERIOD_W-1:0] pcnt;
   logic                have_ref;

   stepdir_input_filter #(.FILTER_LEN(FILTER_LEN)) u_stp_filt (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .pin    (bus.STP),
      .filt   (stp_filt)
   );

   stepdir_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dir_filt (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .pin    (bus.DIR),
      .filt   (dir_filt)
   );

   // A DIR change seen in the same cycle as the step counts as age 0.
   always_comb begin
      step_evt  = stp_filt & ~stp_prev & bus.enable;
      count_evt = step_evt & ~bus.load;
      dir_chg   = dir_filt ^ dir_prev;
      age_eff   = dir_chg ? '0 : age;
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         stp_prev         <= 1'b0;
         dir_prev         <= 1'b0;
         age              <= '0;
         pcnt             <= '0;
         have_ref         <= 1'b0;
         bus.position     <= '0;
         bus.step_pulse   <= 1'b0;
         bus.step_dir     <= 1'b0;
         bus.period       <= '0;
         bus.period_valid <= 1'b0;
         bus.setup_err    <= 1'b0;
      end else begin
         stp_prev <= stp_filt;
         dir_prev <= dir_filt;

         if (dir_chg)
            age <= AGE_W'(1);
         else if (age != AGE_MAX)
            age <= age + AGE_W'(1);

         if (bus.load)
            bus.position <= bus.load_value;
         else if (count_evt)
            bus.position <= dir_filt ? bus.position + POS_W'(1)
                                     : bus.position - POS_W'(1);

         bus.step_pulse <= count_evt;
         if (count_evt)
            bus.step_dir <= dir_filt;

         // have_ref marks that a previous counted step anchors the period.
         if (bus.load || !bus.enable) begin
            pcnt     <= '0;
            have_ref <= 1'b0;
         end else if (count_evt) begin
            pcnt     <= PERIOD_W'(1);
            have_ref <= 1'b1;
         end else if (pcnt != PERIOD_MAX) begin
            pcnt <= pcnt + PERIOD_W'(1);
         end

         bus.period_valid <= count_evt & have_ref;
         if (count_evt && have_ref)
            bus.period <= pcnt;

         if (count_evt && (age_eff < AGE_MAX))
            bus.setup_err <= 1'b1;
         else if (bus.err_clr)
            bus.setup_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stepdir_decoder.sv
// Directed bench for stepdir_decoder with FILTER_LEN=4, DIR_SETUP=8.
module tb_stepdir_decoder;

   logic sysclk;
   logic rst_n;

   stepdir_if #(.POS_W(32), .PERIOD_W(24)) bus ();

   stepdir_decoder #(
      .POS_W      (32),
      .PERIOD_W   (24),
      .FILTER_LEN (4),
      .DIR_SETUP  (8)
   ) dut (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   int n_chk = 0;
   int n_bad = 0;

   int          tcount;
   int          strobes;
   int          lat;
   logic        pv_at;
   logic [23:0] per_at;
   logic        dir_at;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      tcount  = 0;
      strobes = 0;
      lat     = 0;
      pv_at   = 1'b0;
      per_at  = '0;
      dir_at  = 1'b0;
   endtask

   // One clock, sampled 1 ns after the edge; records the first strobe seen.
   task automatic tick();
      @(posedge sysclk);
      #1;
      tcount++;
      if (bus.step_pulse === 1'b1) begin
         strobes++;
         if (strobes == 1) begin
            lat    = tcount;
            pv_at  = bus.period_valid;
            per_at = bus.period;
            dir_at = bus.step_dir;
         end
      end
   endtask

   task automatic run_pulse(input int hi, input int lo);
      clr_mon();
      bus.STP = 1'b1;
      repeat (hi) tick();
      bus.STP = 1'b0;
      repeat (lo) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bus.STP        = 1'b0;
      bus.DIR        = 1'b0;
      bus.enable     = 1'b1;
      bus.load       = 1'b0;
      bus.load_value = '0;
      bus.err_clr    = 1'b0;
      clr_mon();

      repeat (3) tick();
      chk("rst_position", bus.position, 0);
      chk("rst_step_pulse", bus.step_pulse, 0);
      chk("rst_step_dir", bus.step_dir, 0);
      chk("rst_period", bus.period, 0);
      chk("rst_period_valid", bus.period_valid, 0);
      chk("rst_setup_err", bus.setup_err, 0);
      rst_n = 1'b1;

      // Forward counting: 10 pulses, 8 high / 8 low
      bus.DIR = 1'b1;
      repeat (20) tick();
      for (int i = 0; i < 10; i++) begin
         run_pulse(8, 8);
         chk("fwd_strobes", strobes, 1);
         chk("fwd_latency", lat, 7);
         chk("fwd_dir", dir_at, 1);
         chk("fwd_pvalid", pv_at, (i > 0) ? 1 : 0);
         if (i > 0)
            chk("fwd_period", per_at, 16);
      end
      chk("fwd_position", bus.position, 10);
      chk("fwd_noerr", bus.setup_err, 0);

      // Glitch rejection: 3-cycle pulse
      run_pulse(3, 10);
      chk("glitch_strobes", strobes, 0);
      chk("glitch_position", bus.position, 10);

      // Wrap-around, both directions
      bus.load = 1'b1;
      bus.load_value = 32'h7FFF_FFFF;
      tick();
      bus.load = 1'b0;
      chk("load_max", bus.position, 64'h7FFF_FFFF);
      run_pulse(8, 8);
      chk("wrap_up", bus.position, 64'h8000_0000);
      chk("wrap_up_pvalid", pv_at, 0);
      bus.load = 1'b1;
      bus.load_value = 32'h0;
      tick();
      bus.load = 1'b0;
      bus.DIR = 1'b0;
      repeat (20) tick();
      run_pulse(8, 8);
      chk("wrap_down", bus.position, 64'hFFFF_FFFF);
      chk("wrap_down_dir", dir_at, 0);
      chk("wrap_noerr", bus.setup_err, 0);

      // Setup violation: DIR flips 3 cycles before STP
      bus.DIR = 1'b1;
      repeat (3) tick();
      run_pulse(8, 8);
      chk("setup_strobes", strobes, 1);
      chk("setup_dir", dir_at, 1);
      chk("setup_position", bus.position, 0);
      chk("setup_err_set", bus.setup_err, 1);
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      chk("setup_err_clr", bus.setup_err, 0);

      // err_clr on the same edge as a new violation
      bus.DIR = 1'b0;
      repeat (3) tick();
      clr_mon();
      bus.STP = 1'b1;
      repeat (6) tick();
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      chk("coinc_pulse", bus.step_pulse, 1);
      chk("coinc_err", bus.setup_err, 1);
      bus.STP = 1'b0;
      repeat (10) tick();
      chk("coinc_err_sticky", bus.setup_err, 1);
      chk("coinc_position", bus.position, 64'hFFFF_FFFF);

      // load on the same edge as a step event
      repeat (10) tick();
      clr_mon();
      bus.STP = 1'b1;
      repeat (6) tick();
      bus.load = 1'b1;
      bus.load_value = 32'd100;
      tick();
      bus.load = 1'b0;
      chk("ldstep_pulse", bus.step_pulse, 0);
      chk("ldstep_position", bus.position, 100);
      bus.STP = 1'b0;
      repeat (10) tick();
      chk("ldstep_strobes", strobes, 0);
      chk("ldstep_hold", bus.position, 100);
      run_pulse(8, 8);
      chk("after_load_pos", bus.position, 99);
      chk("after_load_pvalid", pv_at, 0);
      run_pulse(8, 8);
      chk("after_load_pos2", bus.position, 98);
      chk("after_load_pvalid2", pv_at, 1);
      chk("after_load_period", per_at, 16);

      // Asynchronous reset mid-pulse
      bus.STP = 1'b1;
      repeat (5) tick();
      rst_n = 1'b0;
      bus.STP = 1'b0;
      #1;
      chk("arst_position", bus.position, 0);
      chk("arst_period", bus.period, 0);
      chk("arst_setup_err", bus.setup_err, 0);
      chk("arst_step_dir", bus.step_dir, 0);
      chk("arst_step_pulse", bus.step_pulse, 0);
      chk("arst_period_valid", bus.period_valid, 0);
      repeat (3) tick();
      rst_n = 1'b1;

      // Resume, then enable = 0 for 5 pulses
      bus.DIR = 1'b1;
      repeat (20) tick();
      run_pulse(8, 8);
      chk("resume_position", bus.position, 1);
      chk("resume_pvalid", pv_at, 0);
      bus.enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         run_pulse(8, 8);
         chk("dis_strobes", strobes, 0);
      end
      chk("dis_position", bus.position, 1);
      chk("dis_period", bus.period, 0);

      // Rising edge filtered while disabled must not count after enable
      clr_mon();
      bus.STP = 1'b1;
      repeat (12) tick();
      bus.enable = 1'b1;
      repeat (4) tick();
      bus.STP = 1'b0;
      repeat (10) tick();
      chk("dis_rise_strobes", strobes, 0);
      chk("dis_rise_position", bus.position, 1);

      run_pulse(8, 8);
      chk("reen_position", bus.position, 2);
      chk("reen_pvalid", pv_at, 0);
      run_pulse(8, 8);
      chk("reen_position2", bus.position, 3);
      chk("reen_pvalid2", pv_at, 1);
      chk("reen_period", per_at, 16);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
